// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and colour-bar palette for the VGA timing controller.
// Default timing is 640x480@60 on a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned HFpDef     = 16;
  localparam int unsigned HSyncDef   = 96;
  localparam int unsigned HBpDef     = 48;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned VFpDef     = 10;
  localparam int unsigned VSyncDef   = 2;
  localparam int unsigned VBpDef     = 33;
  localparam int unsigned HTotalDef  = HActiveDef + HFpDef + HSyncDef + HBpDef;
  localparam int unsigned VTotalDef  = VActiveDef + VFpDef + VSyncDef + VBpDef;
  localparam int unsigned CwDef      = 11;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} vga_state_e;

  localparam logic [23:0] ColWhite   = 24'hFFFFFF;
  localparam logic [23:0] ColYellow  = 24'hFFFF00;
  localparam logic [23:0] ColCyan    = 24'h00FFFF;
  localparam logic [23:0] ColGreen   = 24'h00FF00;
  localparam logic [23:0] ColMagenta = 24'hFF00FF;
  localparam logic [23:0] ColRed     = 24'hFF0000;
  localparam logic [23:0] ColBlue    = 24'h0000FF;
  localparam logic [23:0] ColBlack   = 24'h000000;

  // Bar 0 is the leftmost bar.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    unique case (idx)
      3'd0: col = ColWhite;
      3'd1: col = ColYellow;
      3'd2: col = ColCyan;
      3'd3: col = ColGreen;
      3'd4: col = ColMagenta;
      3'd5: col = ColRed;
      3'd6: col = ColBlue;
      3'd7: col = ColBlack;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus active/sync region decode.
// Decode outputs are combinational from the current count.
module vga_axis_counter #(
  parameter int unsigned Active = 640,
  parameter int unsigned Fp     = 16,
  parameter int unsigned Sync   = 96,
  parameter int unsigned Bp     = 48,
  parameter int unsigned Cw     = 11
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [Cw-1:0] cnt_o,
  output logic          last_o,
  output logic          active_o,
  output logic          sync_o
);

  localparam int unsigned   Total      = Active + Fp + Sync + Bp;
  localparam logic [Cw-1:0] LastC      = Cw'(Total - 1);
  localparam logic [Cw-1:0] ActiveC    = Cw'(Active);
  localparam logic [Cw-1:0] SyncStartC = Cw'(Active + Fp);
  localparam logic [Cw-1:0] SyncEndC   = Cw'(Active + Fp + Sync);

  logic [Cw-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign last_o   = (cnt_q == LastC);
  assign active_o = (cnt_q < ActiveC);
  assign sync_o   = (cnt_q >= SyncStartC) && (cnt_q < SyncEndC);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA/DVI timing sequencer with per-line fetch scheduling and late-fetch detection.
// Define VGA_TIMING_CTRL_TEST_PATTERN_EN to add a 24-bit colour-bar output (rgb).
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned H_FP     = HFpDef,
  parameter int unsigned H_SYNC   = HSyncDef,
  parameter int unsigned H_BP     = HBpDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned V_FP     = VFpDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BP     = VBpDef,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = CwDef
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_req,
  output logic [CW-1:0] line_num,
  input  logic          line_ack,
  output logic          underflow,
  output logic          running
`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
  ,
  output logic [23:0]   rgb
`endif
);

  localparam logic [CW-1:0] HActiveC = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActiveC = CW'(V_ACTIVE);

  vga_state_e    state_q, state_d;
  logic          run_en;
  logic [CW-1:0] hcnt, vcnt, next_line;
  logic          h_last, h_act, h_sync, v_last, v_act, v_sync;

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          line_req_q, line_req_d, underflow_q, underflow_d;
  logic [CW-1:0] line_num_q, line_num_d;

  vga_axis_counter #(
    .Active(H_ACTIVE), .Fp(H_FP), .Sync(H_SYNC), .Bp(H_BP), .Cw(CW)
  ) u_hcnt (
    .clk_i(clk), .reset_i(reset), .clr_i(!run_en), .inc_i(1'b1),
    .cnt_o(hcnt), .last_o(h_last), .active_o(h_act), .sync_o(h_sync)
  );

  vga_axis_counter #(
    .Active(V_ACTIVE), .Fp(V_FP), .Sync(V_SYNC), .Bp(V_BP), .Cw(CW)
  ) u_vcnt (
    .clk_i(clk), .reset_i(reset), .clr_i(!run_en), .inc_i(h_last),
    .cnt_o(vcnt), .last_o(v_last), .active_o(v_act), .sync_o(v_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StPrime;
      StPrime: if (!enable) state_d = StIdle; else if (line_ack) state_d = StRun;
      StRun:   if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counters only advance while RUN is sustained; a falling enable clears them at once.
  always_comb begin
    running = (state_q == StRun);
    run_en  = running && enable;
  end

  always_comb begin
    hsync_d = ~SYNC_POL;
    vsync_d = ~SYNC_POL;
    de_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    fs_d    = 1'b0;
    if (run_en) begin
      hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
      de_d    = h_act && v_act;
      x_d     = de_d ? hcnt : '0;
      y_d     = de_d ? vcnt : '0;
      fs_d    = (hcnt == '0) && (vcnt == '0);
    end
  end

  // A request lives from hblank of line v to the wrap into line v+1; an ack on the
  // wrap cycle itself still counts as on time.
  always_comb begin
    line_req_d  = line_req_q;
    line_num_d  = line_num_q;
    underflow_d = underflow_q;
    next_line   = v_last ? '0 : vcnt + 1'b1;
    if (!enable) begin
      line_req_d = 1'b0;
      line_num_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          line_req_d = 1'b1;
          line_num_d = '0;
        end
        StPrime: if (line_ack) line_req_d = 1'b0;
        StRun: begin
          if (line_req_q && line_ack) begin
            line_req_d = 1'b0;
          end else if (line_req_q && h_last) begin
            line_req_d  = 1'b0;
            underflow_d = 1'b1;
          end
          if (hcnt == HActiveC && next_line < VActiveC) begin
            line_req_d = 1'b1;
            line_num_d = next_line;
          end
        end
        default: line_req_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
      line_req_q  <= 1'b0;
      line_num_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
      line_req_q  <= line_req_d;
      line_num_q  <= line_num_d;
      underflow_q <= underflow_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign line_req    = line_req_q;
  assign line_num    = line_num_q;
  assign underflow   = underflow_q;

`ifdef VGA_TIMING_CTRL_TEST_PATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / 8;

  logic [2:0]  bar_sel;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    bar_sel = 3'(hcnt / CW'(BarW));
    rgb_d   = de_d ? bar_colour(bar_sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule
